// File: rtl/mul_rr_scheduler.sv
// Round-robin scheduler that time-shares one repeated-addition multiplier datapath
// among NREQ requesters and returns each product tagged with the requester id.
module mul_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      data_in,
  output logic                  lda,
  output logic                  ldb,
  output logic                  clrp,
  output logic                  ldp,
  output logic                  decb,
  input  logic                  eqz,
  input  logic [WIDTH-1:0]      p_in,
  output logic                  busy,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data
);

  typedef enum logic [2:0] {S_IDLE, S_LDA, S_LDB, S_MUL, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   last_id_q, last_id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   win_id;
  logic             win_found;

  // Walk candidates from farthest to nearest after last_id so the nearest pending one wins.
  always_comb begin
    cand      = '0;
    win_id    = '0;
    win_found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(last_id_q) + k) % NREQ);
      if (req[cand]) begin
        win_id    = cand;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    id_d        = id_q;
    last_id_d   = last_id_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    data_in     = '0;
    lda         = 1'b0;
    ldb         = 1'b0;
    clrp        = 1'b0;
    ldp         = 1'b0;
    decb        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d     = NREQ'(1) << win_id;
          id_d      = win_id;
          last_id_d = win_id;
          a_d       = op_a[int'(win_id)*WIDTH +: WIDTH];
          b_d       = op_b[int'(win_id)*WIDTH +: WIDTH];
          state_d   = S_LDA;
        end
      end
      S_LDA: begin
        data_in = a_q;
        lda     = 1'b1;
        state_d = S_LDB;
      end
      S_LDB: begin
        data_in = b_q;
        ldb     = 1'b1;
        clrp    = 1'b1;
        state_d = S_MUL;
      end
      S_MUL: begin
        if (!eqz) begin
          ldp  = 1'b1;
          decb = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = p_in;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      id_q        <= '0;
      last_id_q   <= IDW'(NREQ - 1);
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      id_q        <= id_d;
      last_id_q   <= last_id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Directed bench for mul_rr_scheduler with a behavioural A/B/P repeated-addition datapath.
module tb_mul_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] op_a, op_b;
  logic [3:0]  gnt;
  logic [15:0] data_in;
  logic        lda, ldb, clrp, ldp, decb, eqz, busy, rsp_valid;
  logic [15:0] p_in, rsp_data;
  logic [1:0]  rsp_id;

  logic [15:0] dp_a = '0, dp_b = '0, dp_p = '0;
  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (lda) dp_a <= data_in;
    if (ldb) dp_b <= data_in;
    else if (decb) dp_b <= dp_b - 16'd1;
    if (clrp) dp_p <= '0;
    else if (ldp) dp_p <= dp_p + dp_a;
  end
  assign eqz  = (dp_b == 16'd0);
  assign p_in = dp_p;

  mul_rr_scheduler #(.NREQ(4), .WIDTH(16), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .gnt(gnt),
    .data_in(data_in), .lda(lda), .ldb(ldb), .clrp(clrp), .ldp(ldp), .decb(decb),
    .eqz(eqz), .p_in(p_in), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data)
  );

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Runs one op for a single requester; n counts cycles with LDA as cycle 1.
  task automatic do_op(input int id, input logic [15:0] a, input logic [15:0] b,
                       output int lat, output logic [15:0] data, output logic [1:0] rid,
                       output int nlda, output int nldb, output int nldp,
                       output logic [3:0] g, output bit to);
    int cyc;
    int n;
    to = 1'b0; lat = 0; data = '0; rid = '0; nlda = 0; nldb = 0; nldp = 0; g = '0;
    op_a[id*16 +: 16] = a;
    op_b[id*16 +: 16] = b;
    req[id] = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!lda && cyc < 50);
    if (!lda) begin to = 1'b1; req[id] = 1'b0; return; end
    g = gnt;
    n = 1; nlda = 1;
    do begin
      @(negedge clk); n++;
      nlda += int'(lda); nldb += int'(ldb); nldp += int'(ldp);
    end while (!rsp_valid && n < 2000);
    if (!rsp_valid) to = 1'b1;
    lat = n; data = rsp_data; rid = rsp_id;
    req[id] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({gnt, data_in, lda, ldb, clrp, ldp, decb, busy, rsp_valid, rsp_id, rsp_data} !== '0)
      $display("FAIL reset_in: outputs=%h expected 0",
               {gnt, data_in, lda, ldb, clrp, ldp, decb, busy, rsp_valid, rsp_id, rsp_data});
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || gnt !== 4'b0 || rsp_valid !== 1'b0)
      $display("FAIL reset_idle: busy=%b gnt=%b rsp_valid=%b expected 0", busy, gnt, rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat, nlda, nldb, nldp; logic [15:0] d; logic [1:0] id; logic [3:0] g; bit to;
    do_op(0, 16'd17, 16'd5, lat, d, id, nlda, nldb, nldp, g, to);
    total_cnt++;
    if (to) $display("FAIL basic_timeout: timed out, expected completion"); else pass_cnt++;
    total_cnt++;
    if (lat !== 9) $display("FAIL basic_latency: got %0d expected 9", lat); else pass_cnt++;
    total_cnt++;
    if (d !== 16'd85 || id !== 2'd0) $display("FAIL basic_rsp: data=%0d id=%0d expected 85/0", d, id);
    else pass_cnt++;
    total_cnt++;
    if (nlda !== 1 || nldb !== 1 || nldp !== 5)
      $display("FAIL basic_strobes: lda=%0d ldb=%0d ldp=%0d expected 1/1/5", nlda, nldb, nldp);
    else pass_cnt++;
    total_cnt++;
    if (g !== 4'b0001 || busy !== 1'b0 || gnt !== 4'b0)
      $display("FAIL basic_gnt: gnt_op=%b busy_after=%b gnt_after=%b expected 0001/0/0000", g, busy, gnt);
    else pass_cnt++;
  endtask

  task automatic test_b_zero();
    int lat, nlda, nldb, nldp; logic [15:0] d; logic [1:0] id; logic [3:0] g; bit to;
    do_op(1, 16'd9, 16'd0, lat, d, id, nlda, nldb, nldp, g, to);
    total_cnt++;
    if (to || lat !== 4) $display("FAIL bzero_latency: got %0d (timeout=%0d) expected 4", lat, to);
    else pass_cnt++;
    total_cnt++;
    if (d !== 16'd0 || id !== 2'd1 || nldp !== 0 || g !== 4'b0010)
      $display("FAIL bzero_rsp: data=%0d id=%0d ldp=%0d gnt=%b expected 0/1/0/0010", d, id, nldp, g);
    else pass_cnt++;
  endtask

  task automatic test_all_req();
    logic [1:0]  ids [4];
    logic [15:0] ds  [4];
    int got = 0, cyc = 0, bad_gnt = 0;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      op_a[i*16 +: 16] = 16'(i + 2);
      op_b[i*16 +: 16] = 16'd1;
    end
    req = 4'b1111;
    while (got < 4 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (!$onehot0(gnt)) bad_gnt++;
      if (rsp_valid) begin
        ids[got] = rsp_id; ds[got] = rsp_data;
        req[rsp_id] = 1'b0;
        got++;
      end
    end
    req = '0;
    @(negedge clk);
    total_cnt++;
    if (got !== 4) $display("FAIL all_count: got %0d responses expected 4", got); else pass_cnt++;
    for (int i = 0; i < got; i++) begin
      total_cnt++;
      if (ids[i] !== 2'(i) || ds[i] !== 16'(i + 2))
        $display("FAIL all_order%0d: id=%0d data=%0d expected %0d/%0d", i, ids[i], ds[i], i, i + 2);
      else pass_cnt++;
    end
    total_cnt++;
    if (bad_gnt !== 0) $display("FAIL all_onehot: %0d bad gnt cycles expected 0", bad_gnt); else pass_cnt++;
  endtask

  task automatic test_fairness();
    logic [1:0]  ids [4];
    logic [15:0] ds  [4];
    logic [1:0]  exp_id [4];
    int got = 0, cyc = 0;
    exp_id[0] = 2'd0; exp_id[1] = 2'd2; exp_id[2] = 2'd0; exp_id[3] = 2'd2;
    reset_dut();
    op_a[0 +: 16] = 16'd5;  op_b[0 +: 16] = 16'd2;
    op_a[32 +: 16] = 16'd6; op_b[32 +: 16] = 16'd3;
    req = 4'b0101;
    while (got < 4 && cyc < 300) begin
      @(negedge clk); cyc++;
      if (rsp_valid) begin
        ids[got] = rsp_id; ds[got] = rsp_data; got++;
        if (got == 4) req = '0;
      end
    end
    req = '0;
    @(negedge clk);
    total_cnt++;
    if (got !== 4) $display("FAIL fair_count: got %0d responses expected 4", got); else pass_cnt++;
    for (int i = 0; i < got; i++) begin
      total_cnt++;
      if (ids[i] !== exp_id[i] || ds[i] !== (exp_id[i] == 2'd0 ? 16'd10 : 16'd18))
        $display("FAIL fair_order%0d: id=%0d data=%0d expected %0d/%0d", i, ids[i], ds[i],
                 exp_id[i], (exp_id[i] == 2'd0 ? 10 : 18));
      else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    int lat, nlda, nldb, nldp; logic [15:0] d; logic [1:0] id; logic [3:0] g; bit to;
    do_op(3, 16'd300, 16'd300, lat, d, id, nlda, nldb, nldp, g, to);
    total_cnt++;
    if (to || lat !== 304) $display("FAIL ovf_latency: got %0d (timeout=%0d) expected 304", lat, to);
    else pass_cnt++;
    total_cnt++;
    if (d !== 16'd24464 || id !== 2'd3) $display("FAIL ovf_rsp: data=%0d id=%0d expected 24464/3", d, id);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    int lat, nlda, nldb, nldp, cyc, seen; logic [15:0] d; logic [1:0] id; logic [3:0] g; bit to;
    op_a[0 +: 16] = 16'd7; op_b[0 +: 16] = 16'd10;
    req[0] = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!lda && cyc < 50);
    repeat (4) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1 || ldp !== 1'b1) $display("FAIL rst_mid_inmul: busy=%b ldp=%b expected 1/1", busy, ldp);
    else pass_cnt++;
    req = '0;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({gnt, data_in, lda, ldb, clrp, ldp, decb, busy, rsp_valid, rsp_id} !== '0)
      $display("FAIL rst_mid_clear: outputs=%h expected 0",
               {gnt, data_in, lda, ldb, clrp, ldp, decb, busy, rsp_valid, rsp_id});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin @(negedge clk); seen += int'(rsp_valid); end
    total_cnt++;
    if (seen !== 0) $display("FAIL rst_mid_norsp: %0d rsp_valid cycles expected 0", seen); else pass_cnt++;
    do_op(0, 16'd3, 16'd4, lat, d, id, nlda, nldb, nldp, g, to);
    total_cnt++;
    if (to || d !== 16'd12 || id !== 2'd0 || lat !== 8)
      $display("FAIL rst_mid_next: data=%0d id=%0d lat=%0d expected 12/0/8", d, id, lat);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; req = '0; op_a = '0; op_b = '0;
    test_reset();
    test_basic();
    test_b_zero();
    test_all_req();
    test_fairness();
    test_overflow();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
